// File: rtl/mmio_net_bridge_pkg.sv
// Shared register map, STATUS bit positions and sticky mask for the MMIO/Hoplite bridge.
package mmio_net_bridge_pkg;

    localparam logic [4:0] OFF_TX_X       = 5'h00;
    localparam logic [4:0] OFF_TX_Y       = 5'h04;
    localparam logic [4:0] OFF_TX_DATA    = 5'h08;
    localparam logic [4:0] OFF_RX_DATA    = 5'h0C;
    localparam logic [4:0] OFF_STATUS     = 5'h10;
    localparam logic [4:0] OFF_STATUS_CLR = 5'h14;
    localparam logic [4:0] OFF_NODE       = 5'h18;
    localparam logic [4:0] OFF_COORDS     = 5'h1C;

    localparam int unsigned ST_TX_FULL      = 0;
    localparam int unsigned ST_TX_EMPTY     = 1;
    localparam int unsigned ST_RX_EMPTY     = 2;
    localparam int unsigned ST_RX_FULL      = 3;
    localparam int unsigned ST_RX_UNDERFLOW = 4;
    localparam int unsigned ST_BAD_ACCESS   = 5;
    localparam int unsigned ST_RX_COUNT_LSB = 8;

    localparam logic [31:0] STICKY_MASK = 32'h0000_0030;

endpackage

// File: rtl/mmio_net_bridge_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output; dout reads zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; stale words are hidden by the empty gate on dout.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_net_bridge.sv
// PicoRV32 native-bus to Hoplite port bridge with TX/RX FIFOs and sticky status.
// Define MMIO_NET_BRIDGE_BLOCKING_RX_EN to make RX_DATA reads on empty stall instead of underflow.
module mmio_net_bridge
    import mmio_net_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned COORD_BITS  = 1,
    parameter int unsigned DATA_BITS   = 32,
    parameter int unsigned TX_DEPTH    = 4,
    parameter int unsigned RX_DEPTH    = 4,
    parameter int unsigned X_COORD     = 0,
    parameter int unsigned Y_COORD     = 0,
    parameter int unsigned NODE_NUMBER = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  sel,
    output logic [COORD_BITS-1:0] tx_x_coord,
    output logic [COORD_BITS-1:0] tx_y_coord,
    output logic [DATA_BITS-1:0]  tx_message,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_BITS-1:0]  rx_message,
    input  logic                  rx_valid,
    output logic                  rx_ready
);

    localparam int unsigned TxW = 2 * COORD_BITS + DATA_BITS;

    logic                        mem_ready_q;
    logic [31:0]                 mem_rdata_q, rdata_d;
    logic [COORD_BITS-1:0]       tx_x_q, tx_x_d, tx_y_q, tx_y_d;
    logic                        underflow_q, underflow_d, bad_q, bad_d;
    logic                        set_underflow, set_bad;
    logic [31:0]                 clr_mask, status;
    logic [4:0]                  offset;
    logic                        is_write, full_strobe, stall, accept;
    logic                        tx_push, tx_pop, tx_full, tx_empty;
    logic                        rx_push, rx_pop, rx_full, rx_empty;
    logic [TxW-1:0]              tx_dout;
    logic [DATA_BITS-1:0]        rx_dout;
    logic [$clog2(TX_DEPTH):0]   tx_count;
    logic [$clog2(RX_DEPTH):0]   rx_count;
    logic                        unused_bits;

    assign sel         = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign offset      = {mem_addr[4:2], 2'b00};
    assign is_write    = |mem_wstrb;
    assign full_strobe = (mem_wstrb == 4'hF);
    assign unused_bits = ^{mem_addr[1:0], mem_wdata, tx_count};

    always_comb begin
        stall = 1'b0;
        if (is_write && full_strobe && offset == OFF_TX_DATA && tx_full) stall = 1'b1;
`ifdef MMIO_NET_BRIDGE_BLOCKING_RX_EN
        if (!is_write && offset == OFF_RX_DATA && rx_empty) stall = 1'b1;
`endif
    end

    assign accept = sel && !mem_ready_q && !stall;

    always_comb begin
        status                           = '0;
        status[ST_TX_FULL]               = tx_full;
        status[ST_TX_EMPTY]              = tx_empty;
        status[ST_RX_EMPTY]              = rx_empty;
        status[ST_RX_FULL]               = rx_full;
        status[ST_RX_UNDERFLOW]          = underflow_q;
        status[ST_BAD_ACCESS]            = bad_q;
        status[ST_RX_COUNT_LSB +: 8]     = 8'(rx_count);
    end

    always_comb begin
        tx_x_d        = tx_x_q;
        tx_y_d        = tx_y_q;
        tx_push       = 1'b0;
        rx_pop        = 1'b0;
        rdata_d       = '0;
        set_underflow = 1'b0;
        set_bad       = 1'b0;
        clr_mask      = '0;
        if (accept) begin
            if (is_write) begin
                if (!full_strobe) begin
                    set_bad = 1'b1;
                end else begin
                    case (offset)
                        OFF_TX_X:       tx_x_d   = mem_wdata[COORD_BITS-1:0];
                        OFF_TX_Y:       tx_y_d   = mem_wdata[COORD_BITS-1:0];
                        OFF_TX_DATA:    tx_push  = 1'b1;
                        OFF_STATUS_CLR: clr_mask = mem_wdata & STICKY_MASK;
                        default:        set_bad  = 1'b1;
                    endcase
                end
            end else begin
                case (offset)
                    OFF_RX_DATA: begin
                        if (!rx_empty) begin
                            rx_pop  = 1'b1;
                            rdata_d = 32'(rx_dout);
                        end else begin
                            set_underflow = 1'b1;
                        end
                    end
                    OFF_STATUS: rdata_d = status;
                    OFF_NODE:   rdata_d = 32'(NODE_NUMBER);
                    OFF_COORDS: rdata_d = {16'(Y_COORD), 16'(X_COORD)};
                    default:    set_bad = 1'b1;
                endcase
            end
        end
        // A set in the same cycle as a clear leaves the flag set.
        underflow_d = (underflow_q && !clr_mask[ST_RX_UNDERFLOW]) || set_underflow;
        bad_d       = (bad_q && !clr_mask[ST_BAD_ACCESS]) || set_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            tx_x_q      <= '0;
            tx_y_q      <= '0;
            underflow_q <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            mem_ready_q <= accept;
            mem_rdata_q <= rdata_d;
            tx_x_q      <= tx_x_d;
            tx_y_q      <= tx_y_d;
            underflow_q <= underflow_d;
            bad_q       <= bad_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;

    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && rx_ready;

    assign tx_x_coord = tx_dout[TxW-1 -: COORD_BITS];
    assign tx_y_coord = tx_dout[DATA_BITS +: COORD_BITS];
    assign tx_message = tx_dout[DATA_BITS-1:0];

    sync_fifo #(
        .WIDTH (TxW),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .din   ({tx_x_q, tx_y_q, mem_wdata[DATA_BITS-1:0]}),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .din   (rx_message),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

endmodule

// File: tb/tb_mmio_net_bridge.sv
// Self-checking bench for mmio_net_bridge: directed scenarios plus randomized traffic vs queue model.
module tb_mmio_net_bridge;

    localparam int          TXD  = 4;
    localparam int          RXD  = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        sel;
    logic [0:0]  tx_x_coord, tx_y_coord;
    logic [31:0] tx_message;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] rx_message = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    always #5 clk = ~clk;

    mmio_net_bridge #(
        .BASE_ADDR   (BASE),
        .COORD_BITS  (1),
        .DATA_BITS   (32),
        .TX_DEPTH    (TXD),
        .RX_DEPTH    (RXD),
        .X_COORD     (1),
        .Y_COORD     (0),
        .NODE_NUMBER (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .sel        (sel),
        .tx_x_coord (tx_x_coord),
        .tx_y_coord (tx_y_coord),
        .tx_message (tx_message),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_message (rx_message),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [33:0] tx_seen[$];
    logic [33:0] tx_exp[$];
    logic [31:0] rx_exp[$];
    bit          mdl_underflow = 0;
    bit          mdl_bad = 0;
    logic        mdl_x = 0;
    logic        mdl_y = 0;

    // tx_ready only changes just after a rising edge, so it is stable here.
    always @(negedge clk)
        if (!reset && tx_valid && tx_ready) tx_seen.push_back({tx_x_coord, tx_y_coord, tx_message});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] exp_status(input int tx_cnt);
        logic [31:0] s = '0;
        s[0]    = (tx_cnt == TXD);
        s[1]    = (tx_cnt == 0);
        s[2]    = (rx_exp.size() == 0);
        s[3]    = (rx_exp.size() == RXD);
        s[4]    = mdl_underflow;
        s[5]    = mdl_bad;
        s[15:8] = 8'(rx_exp.size());
        return s;
    endfunction

    task automatic set_tx_ready(input logic v);
        @(posedge clk);
        #1 tx_ready = v;
    endtask

    // One bus transaction; returns read data and number of edges until mem_ready.
    task automatic bus_op(input logic [4:0] off, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata, output int lat);
        bit done = 0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE | 32'(off);
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        lat = 0;
        rdata = '0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1 lat++;
            if (mem_ready) begin
                done = 1;
                rdata = mem_rdata;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL bus_timeout off=%0h: no mem_ready after %0d cycles", off, lat);
        end else begin
            @(posedge clk);
            #1 n_checks++;
            if (mem_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_single_pulse off=%0h got %b want 0", off, mem_ready);
            end
        end
    endtask

    task automatic rx_send(input logic [31:0] msg, output bit ok);
        ok = 0;
        @(negedge clk);
        rx_valid   = 1'b1;
        rx_message = msg;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rx_ready) begin
                @(posedge clk);
                #1 ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        rx_valid = 1'b0;
        if (ok) rx_exp.push_back(msg);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ready got %b want 0", mem_ready); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_rdata got %h want 0", mem_rdata); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready got %b want 1", rx_ready); end
        n_checks++;
        if ({tx_x_coord, tx_y_coord, tx_message} !== 34'h0) begin
            n_fail++;
            $display("FAIL rst_tx_head got %h want 0", {tx_x_coord, tx_y_coord, tx_message});
        end
        @(negedge clk) reset = 1'b0;
        bus_op(5'h10, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== exp_status(0)) begin n_fail++; $display("FAIL rst_status got %h want %h", rd, exp_status(0)); end
    endtask

    task automatic test_ready_pulse();
        logic pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE | 32'h10;
        mem_wstrb = 4'h0;
        #1 n_checks++;
        if (sel !== 1'b1) begin n_fail++; $display("FAIL sel_in_window got %b want 1", sel); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 n_checks++;
            if (mem_ready !== pat[i]) begin
                n_fail++;
                $display("FAIL held_valid_ready[%0d] got %b want %b", i, mem_ready, pat[i]);
            end
        end
        mem_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_tx_single();
        logic [31:0] rd;
        int lat;
        bus_op(5'h00, 32'h1, 4'hF, rd, lat); mdl_x = 1'b1;
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL tx_x_latency got %0d want 1", lat); end
        bus_op(5'h04, 32'h1, 4'hF, rd, lat); mdl_y = 1'b1;
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL tx_y_latency got %0d want 1", lat); end
        bus_op(5'h08, 32'hDEADBEEF, 4'hF, rd, lat);
        tx_exp.push_back({mdl_x, mdl_y, 32'hDEADBEEF});
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL tx_data_latency got %0d want 1", lat); end
        n_checks++;
        if (tx_valid !== 1'b1 || {tx_x_coord, tx_y_coord, tx_message} !== tx_exp[0]) begin
            n_fail++;
            $display("FAIL tx_head got v=%b %h want v=1 %h", tx_valid,
                     {tx_x_coord, tx_y_coord, tx_message}, tx_exp[0]);
        end
        set_tx_ready(1'b1);
        repeat (4) @(posedge clk);
        set_tx_ready(1'b0);
        n_checks++;
        if (tx_seen.size() !== 1) begin n_fail++; $display("FAIL tx_single_count got %0d want 1", tx_seen.size()); end
        while (tx_seen.size() > 0 && tx_exp.size() > 0) begin
            logic [33:0] got = tx_seen.pop_front();
            logic [33:0] exp = tx_exp.pop_front();
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL tx_single_beat got %h want %h", got, exp); end
        end
        tx_seen.delete();
        tx_exp.delete();
    endtask

    task automatic test_tx_full_stall();
        logic [31:0] rd, d;
        int lat;
        bus_op(5'h00, 32'h0, 4'hF, rd, lat); mdl_x = 1'b0;
        bus_op(5'h04, 32'h1, 4'hF, rd, lat); mdl_y = 1'b1;
        for (int i = 0; i < TXD; i++) begin
            d = $urandom;
            bus_op(5'h08, d, 4'hF, rd, lat);
            tx_exp.push_back({mdl_x, mdl_y, d});
        end
        bus_op(5'h10, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== exp_status(TXD)) begin n_fail++; $display("FAIL tx_full_status got %h want %h", rd, exp_status(TXD)); end
        d = $urandom;
        tx_exp.push_back({mdl_x, mdl_y, d});
        fork
            bus_op(5'h08, d, 4'hF, rd, lat);
            begin
                @(negedge clk);
                repeat (5) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        join
        // ready raised after 5 edges; pop at 6, accept at 7
        n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL tx_stall_latency got %0d want 7", lat); end
        repeat (10) @(posedge clk);
        n_checks++;
        if (tx_seen.size() !== 5) begin n_fail++; $display("FAIL tx_stall_beats got %0d want 5", tx_seen.size()); end
        for (int i = 0; i < 5 && i < tx_seen.size(); i++) begin
            n_checks++;
            if (tx_seen[i] !== tx_exp[i]) begin
                n_fail++;
                $display("FAIL tx_stall_order[%0d] got %h want %h", i, tx_seen[i], tx_exp[i]);
            end
        end
        tx_seen.delete();
        tx_exp.delete();
    endtask

    task automatic test_rx_fill();
        logic [31:0] rd;
        int lat;
        bit ok;
        for (int i = 1; i <= 4; i++) begin
            rx_send(32'(i), ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rx_send_%0d got not-accepted want accepted", i); end
        end
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_full got %b want 0", rx_ready); end
        @(negedge clk);
        rx_valid   = 1'b1;
        rx_message = 32'h5;
        repeat (3) @(posedge clk);
        #1 rx_valid = 1'b0;
        bus_op(5'h10, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== exp_status(0)) begin n_fail++; $display("FAIL rx_full_status got %h want %h", rd, exp_status(0)); end
        while (rx_exp.size() > 0) begin
            logic [31:0] exp = rx_exp.pop_front();
            bus_op(5'h0C, 0, 4'h0, rd, lat);
            n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rx_read got %h want %h", rd, exp); end
        end
        rx_send(32'h5, ok);
        bus_op(5'h0C, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL rx_read_fifth got %h want 5", rd); end
        if (rx_exp.size() > 0) void'(rx_exp.pop_front());
    endtask

    task automatic test_rx_underflow();
        logic [31:0] rd;
        int lat;
`ifndef MMIO_NET_BRIDGE_BLOCKING_RX_EN
        bus_op(5'h0C, 0, 4'h0, rd, lat);
        mdl_underflow = 1;
        n_checks++; if (rd !== 32'h0 || lat !== 1) begin n_fail++; $display("FAIL rx_empty_read got %h lat %0d want 0 lat 1", rd, lat); end
        bus_op(5'h10, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== exp_status(0)) begin n_fail++; $display("FAIL underflow_status got %h want %h", rd, exp_status(0)); end
        bus_op(5'h14, 32'h10, 4'hF, rd, lat);
        mdl_underflow = 0;
        bus_op(5'h10, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== exp_status(0)) begin n_fail++; $display("FAIL underflow_clr got %h want %h", rd, exp_status(0)); end
`else
        bit ok;
        fork
            bus_op(5'h0C, 0, 4'h0, rd, lat);
            begin
                repeat (10) @(posedge clk);
                rx_send(32'h55, ok);
            end
        join
        if (rx_exp.size() > 0) void'(rx_exp.pop_front());
        n_checks++; if (rd !== 32'h55 || lat < 11) begin n_fail++; $display("FAIL rx_block_read got %h lat %0d want 55 lat>10", rd, lat); end
        bus_op(5'h10, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== exp_status(0)) begin n_fail++; $display("FAIL rx_block_status got %h want %h", rd, exp_status(0)); end
`endif
    endtask

    task automatic test_bad_access();
        logic [31:0] rd;
        int lat;
        int n0 = tx_seen.size();
        bus_op(5'h08, 32'h1234, 4'h3, rd, lat);
        mdl_bad = 1;
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL partial_latency got %0d want 1", lat); end
        repeat (3) @(posedge clk);
        #1 n_checks++;
        if (tx_seen.size() !== n0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_no_beat got beats %0d v=%b want %0d v=0", tx_seen.size(), tx_valid, n0);
        end
        bus_op(5'h10, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== exp_status(0)) begin n_fail++; $display("FAIL bad_status got %h want %h", rd, exp_status(0)); end
        bus_op(5'h14, 32'h20, 4'hF, rd, lat);
        mdl_bad = 0;
        bus_op(5'h00, 0, 4'h0, rd, lat);
        mdl_bad = 1;
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wonly_read got %h want 0", rd); end
        bus_op(5'h10, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== exp_status(0)) begin n_fail++; $display("FAIL wonly_status got %h want %h", rd, exp_status(0)); end
        bus_op(5'h14, 32'h30, 4'hF, rd, lat);
        mdl_bad = 0;
        bus_op(5'h18, 32'hFFFF, 4'hF, rd, lat);
        mdl_bad = 1;
        bus_op(5'h10, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== exp_status(0)) begin n_fail++; $display("FAIL ronly_write_status got %h want %h", rd, exp_status(0)); end
        bus_op(5'h14, 32'h20, 4'hF, rd, lat);
        mdl_bad = 0;
    endtask

    task automatic test_coords();
        logic [31:0] rd;
        int lat;
        bus_op(5'h1C, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL coords got %h want 00000001", rd); end
        bus_op(5'h18, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL node_number got %h want 5", rd); end
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h2000_0008;
        mem_wstrb = 4'h0;
        #1 n_checks++;
        if (sel !== 1'b0) begin n_fail++; $display("FAIL sel_out_window got %b want 0", sel); end
        repeat (2) @(posedge clk);
        #1 n_checks++;
        if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL out_window_ready got %b want 0", mem_ready); end
        mem_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] rd, d;
        int lat;
        bit ok;
        for (int it = 0; it < 80; it++) begin
            d = $urandom;
            case ($urandom_range(0, 7))
                0: begin bus_op(5'h00, d, 4'hF, rd, lat); mdl_x = d[0]; end
                1: begin bus_op(5'h04, d, 4'hF, rd, lat); mdl_y = d[0]; end
                2: begin bus_op(5'h08, d, 4'hF, rd, lat); tx_exp.push_back({mdl_x, mdl_y, d}); end
                3: if (rx_exp.size() < RXD) begin
                    rx_send(d, ok);
                    n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_rx_send got not-accepted want accepted"); end
                end
                4: begin
                    logic [31:0] exp = 32'h0;
                    bit skip = 0;
                    if (rx_exp.size() > 0) exp = rx_exp.pop_front();
`ifdef MMIO_NET_BRIDGE_BLOCKING_RX_EN
                    else skip = 1;
`else
                    else mdl_underflow = 1;
`endif
                    if (!skip) begin
                        bus_op(5'h0C, 0, 4'h0, rd, lat);
                        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rand_rx_read got %h want %h", rd, exp); end
                    end
                end
                5: begin
                    bus_op(5'h10, 0, 4'h0, rd, lat);
                    n_checks++; if (rd !== exp_status(0)) begin n_fail++; $display("FAIL rand_status got %h want %h", rd, exp_status(0)); end
                end
                6: begin
                    bus_op(5'($urandom_range(0, 7) * 4), d, 4'($urandom_range(1, 14)), rd, lat);
                    mdl_bad = 1;
                end
                default: begin
                    bus_op(5'h14, d, 4'hF, rd, lat);
                    if (d[4]) mdl_underflow = 0;
                    if (d[5]) mdl_bad = 0;
                end
            endcase
        end
        repeat (5) @(posedge clk);
        n_checks++;
        if (tx_seen.size() !== tx_exp.size()) begin
            n_fail++;
            $display("FAIL rand_tx_count got %0d want %0d", tx_seen.size(), tx_exp.size());
        end
        for (int i = 0; i < tx_seen.size() && i < tx_exp.size(); i++) begin
            n_checks++;
            if (tx_seen[i] !== tx_exp[i]) begin
                n_fail++;
                $display("FAIL rand_tx_beat[%0d] got %h want %h", i, tx_seen[i], tx_exp[i]);
            end
        end
        tx_seen.delete();
        tx_exp.delete();
    endtask

    task automatic test_reset_mid_stall();
        logic [31:0] rd;
        int lat;
        bit ok;
        bit saw_ready = 0;
        set_tx_ready(1'b0);
        for (int i = 0; i < TXD; i++) bus_op(5'h08, $urandom, 4'hF, rd, lat);
        while (rx_exp.size() < RXD) begin
            rx_send($urandom, ok);
            if (!ok) break;
        end
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE | 32'h08;
        mem_wdata = 32'hCAFE_F00D;
        mem_wstrb = 4'hF;
        repeat (3) begin
            @(posedge clk);
            #1 if (mem_ready) saw_ready = 1;
        end
        n_checks++; if (saw_ready) begin n_fail++; $display("FAIL stall_ready got 1 want 0"); end
        @(negedge clk);
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(posedge clk);
        #1 n_checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got tx_valid=%b rx_ready=%b ready=%b want 0 1 0", tx_valid, rx_ready, mem_ready);
        end
        @(negedge clk) reset = 1'b0;
        rx_exp.delete();
        tx_exp.delete();
        tx_seen.delete();
        mdl_underflow = 0;
        mdl_bad = 0;
        saw_ready = 0;
        repeat (3) begin
            @(posedge clk);
            #1 if (mem_ready) saw_ready = 1;
        end
        n_checks++; if (saw_ready) begin n_fail++; $display("FAIL post_reset_ready got 1 want 0"); end
        bus_op(5'h10, 0, 4'h0, rd, lat);
        n_checks++; if (rd !== exp_status(0)) begin n_fail++; $display("FAIL post_reset_status got %h want %h", rd, exp_status(0)); end
    endtask

    initial begin
        test_reset();
        test_ready_pulse();
        test_tx_single();
        test_tx_full_stall();
        test_rx_fill();
        test_rx_underflow();
        test_bad_access();
        test_coords();
        test_random();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
